// File: rtl/sum_seq_ctrl_if.sv
// Operand/result bundle for the nibble-serial add/subtract controller.
//   master : operand source (drives start/sub/a/b, observes status and result)
//   slave  : sum_seq_ctrl (observes request, drives busy/done/result/co/ov)
interface sum_seq_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         ov;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, co, ov
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, co, ov
    );
endinterface

// File: rtl/sum_seq_ctrl.sv
// Wide add/subtract sequenced through one 4-bit ripple-carry nibble adder,
// least-significant nibble first, one nibble per clock.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sum_seq_ctrl_if.slave: start/sub/a/b in; busy/done/result/co/ov out
module sum_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    sum_seq_ctrl_if.slave  bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned LAST = NIBBLES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [3:0]      nib_a_c;
    logic [3:0]      nib_b_c;
    logic [3:0]      nib_sum_c;
    logic [4:0]      nib_carry_c;
    logic            last_c;

    // Current nibble pair; subtract already folded into b_lat and carry.
    assign nib_a_c = 4'(a_lat >> {idx, 2'b00});
    assign nib_b_c = 4'(b_lat >> {idx, 2'b00});
    assign last_c  = (idx == IDXW'(LAST));

    // Four chained single-bit full adders (ripple carry).
    always_comb begin
        nib_carry_c    = '0;
        nib_sum_c      = '0;
        nib_carry_c[0] = carry;
        for (int k = 0; k < 4; k++) begin
            nib_sum_c[k]     = nib_a_c[k] ^ nib_b_c[k] ^ nib_carry_c[k];
            nib_carry_c[k+1] = (nib_a_c[k] & nib_b_c[k]) |
                               (nib_carry_c[k] & (nib_a_c[k] ^ nib_b_c[k]));
        end
    end

    // Controller: state, operand latches, nibble index and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_lat      <= '0;
            b_lat      <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.co     <= 1'b0;
            bus.ov     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                // DONE accepts start just like IDLE for back-to-back ops.
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_lat      <= bus.a;
                        b_lat      <= bus.sub ? ~bus.b : bus.b;
                        carry      <= bus.sub;
                        idx        <= '0;
                        bus.result <= '0;
                        bus.busy   <= 1'b1;
                        state      <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    bus.result[{idx, 2'b00} +: 4] <= nib_sum_c;
                    carry <= nib_carry_c[4];
                    idx   <= idx + IDXW'(1);
                    if (last_c) begin
                        // Signed overflow: carry into sign bit vs carry out of it.
                        bus.co   <= nib_carry_c[4];
                        bus.ov   <= nib_carry_c[3] ^ nib_carry_c[4];
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl against an arithmetic reference model.
module tb_sum_seq_ctrl;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    sum_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic plus signed-overflow rule on sign bits.
    typedef struct packed {
        logic         ov;
        logic         co;
        logic [W-1:0] r;
    } exp_t;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        logic [W:0]  s;
        logic [W-1:0] bb;
        bb   = sub ? ~b : b;
        s    = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        e.r  = s[W-1:0];
        e.co = s[W];
        if (sub) e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        else     e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    // Present a request now; it is sampled at the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    // Follow an accepted op through RUN to DONE; optionally pulse an ignored start.
    task automatic follow(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int inject_at);
        exp_t         e;
        logic [W-1:0] mask;
        e = model(a, b, sub);
        check("run_busy0", 32'(bus.busy), 32'd1);
        check("run_done0", 32'(bus.done), 32'd0);
        check("run_res0",  32'(bus.result), 32'd0);
        for (int j = 1; j <= int'(NIBBLES); j++) begin
            if (j == inject_at) begin
                bus.start = 1'b1;
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.sub   = 1'($urandom);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (j < int'(NIBBLES)) begin
                mask = W'((64'd1 << (4 * j)) - 64'd1);
                check("part_busy", 32'(bus.busy), 32'd1);
                check("part_done", 32'(bus.done), 32'd0);
                check("part_res",  32'(bus.result), 32'(e.r & mask));
            end else begin
                check("fin_done", 32'(bus.done), 32'd1);
                check("fin_busy", 32'(bus.busy), 32'd0);
                check("fin_res",  32'(bus.result), 32'(e.r));
                check("fin_co",   32'(bus.co), 32'(e.co));
                check("fin_ov",   32'(bus.ov), 32'(e.ov));
            end
        end
    endtask

    // One idle cycle after DONE: pulse gone, outputs held.
    task automatic idle_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        e = model(a, b, sub);
        @(posedge clk); #1;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_res",  32'(bus.result), 32'(e.r));
        check("idle_co",   32'(bus.co), 32'(e.co));
        check("idle_ov",   32'(bus.ov), 32'(e.ov));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input int inject_at);
        @(negedge clk);
        issue(a, b, sub);
        follow(a, b, sub, inject_at);
        idle_check(a, b, sub);
    endtask

    initial begin
        logic [W-1:0] ra, rb, pa, pb;
        logic         rs, ps;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res",  32'(bus.result), 32'd0);
        check("rst_co",   32'(bus.co), 32'd0);
        check("rst_ov",   32'(bus.ov), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        op(16'h1234, 16'h4321, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 0);
        op(16'h0005, 16'h0007, 1'b1, 0);
        op(16'h8000, 16'h0001, 1'b1, 0);

        // Back-to-back: new start presented during DONE.
        @(negedge clk);
        issue(16'h7FFF, 16'h0001, 1'b0);
        follow(16'h7FFF, 16'h0001, 1'b0, 0);
        issue(16'h0100, 16'h0F00, 1'b1);
        follow(16'h0100, 16'h0F00, 1'b1, 0);
        idle_check(16'h0100, 16'h0F00, 1'b1);

        // Start pulsed at RUN cycle 2 is ignored; only one done pulse follows.
        op(16'h2468, 16'h1357, 1'b0, 2);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("no_extra_done", 32'(bus.done), 32'd0);
        end

        // Leave co/ov set, then reset mid-RUN.
        op(16'h8000, 16'h0001, 1'b1, 0);
        @(negedge clk);
        issue(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_res",  32'(bus.result), 32'd0);
        check("mrst_co",   32'(bus.co), 32'd0);
        check("mrst_ov",   32'(bus.ov), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("mrst_nodone", 32'(bus.done), 32'd0);
        end
        op(16'hABCD, 16'h1234, 1'b0, 0);

        // Randomized ops, with random ignored starts and back-to-back chains.
        pa = W'($urandom); pb = W'($urandom); ps = 1'($urandom);
        @(negedge clk);
        issue(pa, pb, ps);
        for (int n = 0; n < 60; n++) begin
            follow(pa, pb, ps, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NIBBLES)) : 0);
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ra[W-1] = rb[W-1];
            end
            if ($urandom_range(0, 1) == 0) begin
                issue(ra, rb, rs);
            end else begin
                idle_check(pa, pb, ps);
                @(negedge clk);
                issue(ra, rb, rs);
            end
            pa = ra; pb = rb; ps = rs;
        end
        follow(pa, pb, ps, 0);
        idle_check(pa, pb, ps);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_seq_ctrl.md
Name: sum_seq_ctrl

Overview:
- Sequencing controller that performs wide add/subtract by reusing one 4-bit ripple-carry nibble adder (sum1bcc-based) once per clock, least-significant nibble first.
- Latches operands on a start handshake, steps a nibble index and carry register, and assembles the result.
- Signals completion with a one-cycle done pulse.
- Sits between the lab's operand source (switches/MCU register interface) and the display/readback logic.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to begin an operation; sampled on clk edge
- sub  in  1  0 = add (a+b), 1 = subtract (a-b); latched with operands
- a  in  W  operand A, latched on accepted start
- b  in  W  operand B, latched on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse when result becomes valid
- result  out  W  sum/difference; valid from done pulse until next accepted start
- co  out  1  carry out of MSB nibble (for sub: 1 = no borrow)
- ov  out  1  signed two's-complement overflow

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, co=0, ov=0, nibble index=0, carry register=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 on an edge → latch a, b (b bitwise inverted if sub=1) and sub.
  - carry register ← sub (carry-in 1 for subtract), index ← 0, result ← 0, state → RUN.
- RUN, per cycle:
  - Nibble adder computes a_lat[4i+3:4i] + b_lat[4i+3:4i] + carry; sum nibble written to result[4i+3:4i]; carry register ← nibble carry-out; index ← i+1.
  - On i = NIBBLES-1: co ← final carry; ov ← carry into MSB XOR carry out of MSB (computed from bit 3 of top nibble); state → DONE.
- DONE: done=1 for exactly this one cycle; next edge → IDLE. A start sampled in DONE is accepted exactly as in IDLE (state → RUN), giving back-to-back operations with no idle gap.
- busy=1 exactly in RUN (NIBBLES cycles); 0 in IDLE and DONE.
- Latency: start accepted at edge k → done high during the cycle after edge k+NIBBLES (NIBBLES+1 edges from start to done).
- start while busy=1 is ignored (no queuing); a/b/sub may change freely during RUN without effect.
- result/co/ov hold their values in IDLE until the next accepted start, which clears result to 0; co and ov hold until the final nibble of the new operation.
- result bits above the current index read 0 during RUN (partial result visible).
- Arithmetic is modulo 2^W; no saturation.
- Reset asserted mid-RUN aborts immediately to the reset values above; no done pulse is generated.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, sub=0, start 1 cycle → busy high 4 cycles, done pulse on 5th cycle after start edge, result=0x5555, co=0, ov=0.
- a=0xFFFF, b=0x0001, add → result=0x0000, co=1, ov=0; carry ripples across all 4 nibble steps (check partial result each cycle).
- a=0x0005, b=0x0007, sub=1 → result=0xFFFE, co=0 (borrow), ov=0; then a=0x8000, b=0x0001, sub=1 → result=0x7FFF, co=1, ov=1.
- a=0x7FFF, b=0x0001, add → result=0x8000, ov=1, co=0; start re-asserted during DONE → new op starts with no idle cycle.
- Pulse start again at RUN cycle 2 with different operands → ignored; result matches the first operands; only one done pulse.
- Assert rst at RUN cycle 2 → busy, done, result, co, ov all 0 immediately; no done pulse; next start completes normally.
